phase_meas_ctrl: RTL and testbench

Sequencer for the time-domain phase-difference core. On a start request it:
- resets the core
- discards warm-up results
- gates ADC samples into the core
- averages 2^k accepted phase results, filtered by confidence
- reports one averaged phase with a status code

A watchdog and a reject limit guarantee every run terminates.

---
 rtl/phase_meas_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_phase_meas_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_meas_ctrl.sv
// phase_meas_ctrl: run sequencer for the time-domain phase-difference core.
// A run does the following in order:
//   - clear the core
//   - discard its warm-up results
//   - average 2^k confidence-filtered results
//   - report one phase with a status code
// A watchdog and a reject limit bound every run.
module phase_meas_ctrl #(
    parameter int CLEAR_CYCLES   = 4,
    parameter int SETTLE_RESULTS = 2,
    parameter int TIMEOUT_CYCLES = 1400000,
    parameter int MAX_REJECT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  avg_log2,
    input  logic [7:0]  conf_min,
    input  logic        adc_valid_in,
    output logic        adc_valid_out,
    output logic        core_rst_n,
    input  logic [15:0] phase_in,
    input  logic        phase_valid_in,
    input  logic [7:0]  confidence_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [15:0] phase_avg,
    output logic [4:0]  accepted_cnt,
    output logic [7:0]  rejected_cnt
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_RESULTS + 2);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_REJECT  = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_COLLECT,
        S_DIVIDE
    } state_t;

    state_t             state_q, state_d;
    logic               pv_q;
    logic               evt;
    logic               accept;
    logic               wd_exp;
    logic [2:0]         k_q;
    logic [4:0]         n_val;
    logic signed [19:0] acc_q;
    logic signed [19:0] ph_ext;
    logic signed [19:0] half;
    logic [15:0]        rnd;
    logic [CLR_W-1:0]   clr_cnt_q;
    logic [SET_W-1:0]   set_cnt_q;
    logic [WD_W-1:0]    wd_q;

    // control strobes from the next-state logic into the datapath
    logic       go_start, take, rej, wd_rld, div, fin;
    logic [1:0] fin_err;

    // one event per rising edge of the core valid, however long it is held
    assign evt    = phase_valid_in & ~pv_q;
    assign accept = confidence_in >= conf_min;
    assign wd_exp = wd_q == WD_W'(TIMEOUT_CYCLES - 1);
    assign n_val  = 5'd1 << k_q;
    assign ph_ext = {{4{phase_in[15]}}, phase_in};
    // N>>1 rounding addend; zero when N=1
    assign half   = {15'd0, n_val[4:1]};
    assign rnd    = 16'((acc_q + half) >>> k_q);

    assign busy          = state_q != S_IDLE;
    assign adc_valid_out = adc_valid_in & ((state_q == S_SETTLE) | (state_q == S_COLLECT));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state and per-cycle control; abort overrides everything last
    always_comb begin
        state_d  = state_q;
        go_start = 1'b0;
        take     = 1'b0;
        rej      = 1'b0;
        wd_rld   = 1'b0;
        div      = 1'b0;
        fin      = 1'b0;
        fin_err  = ERR_OK;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    go_start = 1'b1;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = (SETTLE_RESULTS == 0) ? S_COLLECT : S_SETTLE;
                    wd_rld  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (evt) begin
                    wd_rld = 1'b1;
                    if (set_cnt_q == SET_W'(SETTLE_RESULTS - 1)) state_d = S_COLLECT;
                end else if (wd_exp) begin
                    fin     = 1'b1;
                    fin_err = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (evt) begin
                    wd_rld = 1'b1;
                    if (accept) begin
                        take = 1'b1;
                        if (accepted_cnt + 5'd1 == n_val) state_d = S_DIVIDE;
                    end else begin
                        rej = 1'b1;
                        if ({1'b0, rejected_cnt} + 9'd1 >= 9'(MAX_REJECT)) begin
                            fin     = 1'b1;
                            fin_err = ERR_REJECT;
                            state_d = S_IDLE;
                        end
                    end
                end else if (wd_exp) begin
                    fin     = 1'b1;
                    fin_err = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end
            end
            S_DIVIDE: begin
                div     = 1'b1;
                fin     = 1'b1;
                fin_err = ERR_OK;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            take    = 1'b0;
            rej     = 1'b0;
            wd_rld  = 1'b0;
            div     = 1'b0;
            fin     = 1'b1;
            fin_err = ERR_ABORT;
        end
    end

    // datapath: counters, accumulator, watchdog, registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q         <= 1'b0;
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            err_code     <= ERR_OK;
            phase_avg    <= '0;
            accepted_cnt <= '0;
            rejected_cnt <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            clr_cnt_q    <= '0;
            set_cnt_q    <= '0;
            wd_q         <= '0;
        end else begin
            pv_q       <= phase_valid_in;
            core_rst_n <= state_d != S_CLEAR;
            done       <= fin;
            if (fin) err_code <= fin_err;
            if (go_start) begin
                k_q          <= (avg_log2 > 3'd4) ? 3'd4 : avg_log2;
                acc_q        <= '0;
                accepted_cnt <= '0;
                rejected_cnt <= '0;
                clr_cnt_q    <= '0;
                set_cnt_q    <= '0;
                err_code     <= ERR_OK;
            end
            if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
            if (state_q == S_SETTLE && evt) set_cnt_q <= set_cnt_q + 1'b1;
            if (wd_rld)
                wd_q <= '0;
            else if (state_q == S_SETTLE || state_q == S_COLLECT)
                wd_q <= wd_q + 1'b1;
            if (take) begin
                acc_q        <= acc_q + ph_ext;
                accepted_cnt <= accepted_cnt + 5'd1;
            end
            if (rej && rejected_cnt != 8'hFF) rejected_cnt <= rejected_cnt + 8'd1;
            if (div) phase_avg <= rnd;
        end
    end

endmodule

// File: tb/tb_phase_meas_ctrl.sv
// Bench for phase_meas_ctrl: directed runs, each pushing its expected
// completion record; a negedge monitor pops and compares on every done.
module tb_phase_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  avg_log2 = '0;
    logic [7:0]  conf_min = '0;
    logic        adc_valid_in = 1'b0;
    logic        adc_valid_out;
    logic        core_rst_n;
    logic [15:0] phase_in = '0;
    logic        phase_valid_in = 1'b0;
    logic [7:0]  confidence_in = '0;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [15:0] phase_avg;
    logic [4:0]  accepted_cnt;
    logic [7:0]  rejected_cnt;

    phase_meas_ctrl #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .avg_log2(avg_log2), .conf_min(conf_min),
        .adc_valid_in(adc_valid_in), .adc_valid_out(adc_valid_out),
        .core_rst_n(core_rst_n), .phase_in(phase_in),
        .phase_valid_in(phase_valid_in), .confidence_in(confidence_in),
        .busy(busy), .done(done), .err_code(err_code), .phase_avg(phase_avg),
        .accepted_cnt(accepted_cnt), .rejected_cnt(rejected_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  err;
        logic [15:0] avg;
        logic [4:0]  acc;
        logic [7:0]  rej;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_avg = '0;
    int          cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] e, input logic [15:0] a, input logic [4:0] ac, input logic [7:0] rj);
        exp_t x;
        x.err = e; x.avg = a; x.acc = ac; x.rej = rj;
        sbq.push_back(x);
        if (e == 2'd0) last_avg = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse; returns one cycle later with the DUT in CLEAR
    task automatic start_run(input logic [2:0] k, input logic [7:0] cmin);
        avg_log2 = k;
        conf_min = cmin;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] ph, input logic [7:0] cf, input int hold);
        phase_in = ph;
        confidence_in = cf;
        phase_valid_in = 1'b1;
        repeat (hold) tick();
        phase_valid_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy) check("idle_bound", {31'd0, busy}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("err_code", {30'd0, err_code}, {30'd0, mon_e.err});
                check("phase_avg", {16'd0, phase_avg}, {16'd0, mon_e.avg});
                check("accepted_cnt", {27'd0, accepted_cnt}, {27'd0, mon_e.acc});
                check("rejected_cnt", {24'd0, rejected_cnt}, {24'd0, mon_e.rej});
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {30'd0, err_code}, 32'd0);
        check("rst_avg", {16'd0, phase_avg}, 32'd0);
        check("rst_acc", {27'd0, accepted_cnt}, 32'd0);
        check("rst_rej", {24'd0, rejected_cnt}, 32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        rst = 1'b0;
        tick();
        check("core_rst_n_release", {31'd0, core_rst_n}, 32'd1);

        // 1: held valids, one event each, +450 average; gating
        adc_valid_in = 1'b1;
        #1;
        check("adc_gate_idle", {31'd0, adc_valid_out}, 32'd0);
        push(2'd0, 16'd450, 5'd4, 8'd0);
        start_run(3'd2, 8'd100);
        check("adc_gate_clear", {31'd0, adc_valid_out}, 32'd0);
        repeat (5) tick();
        repeat (4) pulse(16'd450, 8'd255, 5);
        check("adc_gate_collect_hi", {31'd0, adc_valid_out}, 32'd1);
        adc_valid_in = 1'b0;
        #1;
        check("adc_gate_collect_lo", {31'd0, adc_valid_out}, 32'd0);
        repeat (2) pulse(16'd450, 8'd255, 5);
        wait_idle(50);

        // 2: negative rounding, -43 -> -11; N-th edge to done latency
        push(2'd0, 16'hFFF5, 5'd4, 8'd0);
        start_run(3'd2, 8'd100);
        repeat (5) tick();
        repeat (2) pulse(16'd0, 8'd0, 2);
        pulse(16'hFFF6, 8'd255, 2);
        pulse(16'hFFF5, 8'd255, 2);
        pulse(16'hFFF5, 8'd255, 2);
        phase_in = 16'hFFF5;
        confidence_in = 8'd255;
        phase_valid_in = 1'b1;
        tick();
        check("lat_divide", {31'd0, done}, 32'd0);
        tick();
        check("lat_done", {31'd0, done}, 32'd1);
        phase_valid_in = 1'b0;
        wait_idle(50);

        // 3: alternating confidence, one reject
        push(2'd0, 16'd900, 5'd2, 8'd1);
        start_run(3'd1, 8'd100);
        repeat (5) tick();
        repeat (2) pulse(16'd900, 8'd50, 2);
        pulse(16'd900, 8'd255, 2);
        pulse(16'd900, 8'd50, 2);
        pulse(16'd900, 8'd255, 2);
        wait_idle(50);

        // 4: watchdog, 1000 cycles from SETTLE entry
        push(2'd1, last_avg, 5'd0, 8'd0);
        adc_valid_in = 1'b1;
        start_run(3'd0, 8'd0);
        cnt = 0;
        while (!adc_valid_out && cnt < 20) begin
            tick();
            cnt++;
        end
        cnt = 0;
        while (!done && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", cnt, 32'd1000);
        adc_valid_in = 1'b0;
        wait_idle(20);

        // 5a: abort on the same cycle as an accepted edge
        push(2'd3, last_avg, 5'd0, 8'd0);
        start_run(3'd1, 8'd100);
        repeat (5) tick();
        repeat (2) pulse(16'd100, 8'd255, 2);
        phase_in = 16'd500;
        confidence_in = 8'd255;
        phase_valid_in = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", {31'd0, done}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        phase_valid_in = 1'b0;
        repeat (2) tick();

        // 5b: start during CLEAR is ignored, CLEAR stays 4 cycles
        push(2'd3, last_avg, 5'd0, 8'd0);
        start_run(3'd2, 8'd100);
        cnt = core_rst_n ? 0 : 1;
        tick();
        if (!core_rst_n) cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!core_rst_n && cnt < 20) begin
            cnt++;
            tick();
        end
        check("clear_len", cnt, 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle(20);

        // avg_log2 above 4 clamps to N=16
        push(2'd0, 16'd100, 5'd16, 8'd0);
        start_run(3'd5, 8'd100);
        repeat (5) tick();
        repeat (2) pulse(16'd0, 8'd0, 1);
        repeat (16) pulse(16'd100, 8'd255, 1);
        wait_idle(50);

        // reject limit
        push(2'd2, last_avg, 5'd0, 8'd64);
        start_run(3'd7, 8'd10);
        repeat (5) tick();
        repeat (2) pulse(16'd0, 8'd0, 1);
        repeat (64) pulse(16'd300, 8'd0, 1);
        wait_idle(50);

        // 6: reset in COLLECT
        start_run(3'd2, 8'd100);
        repeat (5) tick();
        repeat (2) pulse(16'd50, 8'd255, 2);
        pulse(16'd50, 8'd255, 2);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_acc", {27'd0, accepted_cnt}, 32'd0);
        check("midrst_avg", {16'd0, phase_avg}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("midrst_release", {31'd0, core_rst_n}, 32'd1);
        repeat (5) tick();
        check("sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
